bwm_div: RTL and testbench

- Sequential signed divider: the inverse of the team's Baugh-Wooley signed multiplier.
- Takes a two's-complement product-width dividend and an operand-width divisor.
- Returns a truncating (round-toward-zero) quotient and remainder after a fixed number of cycles.
- Uses a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic datapath, so p / b recovers a when p = a*b.

---
 rtl/bwm_div.sv | 112 +++++++++++
 tb/tb_bwm_div.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/bwm_div.sv
// Sequential signed divider (restoring, on magnitudes) with start/busy/done handshake.
// Truncating quotient/remainder; the inverse of the Baugh-Wooley signed multiplier.
module bwm_div #(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [M-1:0] b,
  output logic [N-1:0] q,
  output logic [M-1:0] r,
  output logic         busy,
  output logic         done,
  output logic         dz,
  output logic         ovf
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [N-1:0]  dvd;       // dividend magnitude shifting out, quotient bits shifting in
  logic [N:0]    rem;
  logic [M-1:0]  b_mag;
  logic          sign_a, sign_b, zero_b, ovf_case;
  logic [N:0]    trial;
  logic [N:0]    b_ext;
  logic          q_bit;
  logic          unused_bits;

  assign trial       = {rem[N-1:0], dvd[N-1]};
  assign b_ext       = {{(N+1-M){1'b0}}, b_mag};
  assign q_bit       = (trial >= b_ext);
  assign busy        = (state != IDLE);
  // The partial remainder never exceeds |b|, so its top bit is structurally zero.
  assign unused_bits = rem[N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: defaulting state_nxt before the case keeps every path assigned, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = CALC;
      CALC: if (cnt == CW'(N - 1)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every register here, outputs included, is cleared by the async reset so an abort leaves no stale state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      dvd      <= '0;
      rem      <= '0;
      b_mag    <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      zero_b   <= 1'b0;
      ovf_case <= 1'b0;
      q        <= '0;
      r        <= '0;
      done     <= 1'b0;
      dz       <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; the later done <= 1 in FIX overrides this default.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd      <= a[N-1] ? -a : a;
            b_mag    <= b[M-1] ? -b : b;
            rem      <= '0;
            cnt      <= '0;
            sign_a   <= a[N-1];
            sign_b   <= b[M-1];
            zero_b   <= (b == '0);
            ovf_case <= (a == {1'b1, {(N-1){1'b0}}}) && (b == '1);
          end
        end
        CALC: begin
          rem <= q_bit ? (trial - b_ext) : trial;
          dvd <= {dvd[N-2:0], q_bit};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          if (zero_b) begin
            q <= '0;
            r <= '0;
          end else begin
            q <= (sign_a ^ sign_b) ? -dvd : dvd;
            r <= sign_a ? -rem[M-1:0] : rem[M-1:0];
          end
          dz   <= zero_b;
          ovf  <= ovf_case & ~zero_b;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bwm_div.sv
// Directed and randomised checks of bwm_div: results, flags, latency, handshake and reset abort.
module tb_bwm_div;

  localparam int N = 8;
  localparam int M = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a, q;
  logic [M-1:0] b, r;
  logic         busy, done, dz, ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bwm_div #(.N(N), .M(M)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .q(q), .r(r), .busy(busy), .done(done), .dz(dz), .ovf(ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen (or the bound expires).
  task automatic run_op(input logic [N-1:0] aa, input logic [M-1:0] bb,
                        output int lat, output int busy_cyc);
    a = aa; b = bb; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    busy_cyc = int'(busy);
    while (!done && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      busy_cyc += int'(busy);
    end
  endtask

  task automatic directed(input string tag, input logic [N-1:0] aa, input logic [M-1:0] bb,
                          input logic [N-1:0] eq, input logic [M-1:0] er,
                          input logic edz, input logic eovf);
    int lat, bc;
    run_op(aa, bb, lat, bc);
    check({tag, " latency"}, 32'(lat), 32'd9);
    check({tag, " busy"},    32'(bc),  32'd9);
    check({tag, " done"},    32'(done), 32'd1);
    check({tag, " q"},       32'(q),   32'(eq));
    check({tag, " r"},       32'(r),   32'(er));
    check({tag, " dz"},      32'(dz),  32'(edz));
    check({tag, " ovf"},     32'(ovf), 32'(eovf));
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " q"},    32'(q),    32'd0);
    check({tag, " r"},    32'(r),    32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " dz"},   32'(dz),   32'd0);
    check({tag, " ovf"},  32'(ovf),  32'd0);
  endtask

  initial begin
    int ndone, lat, bc, ia, ib, qi, ri;
    logic [N-1:0] ra, eq;
    logic [M-1:0] rb, er;
    logic         edz, eovf;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #12;
    check_idle_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Each op starts in the done cycle of the previous one, so these also cover back-to-back.
    directed("100/7",   8'h64, 4'h7, 8'h0E, 4'h2, 1'b0, 1'b0);
    directed("-100/7",  8'h9C, 4'h7, 8'hF2, 4'hE, 1'b0, 1'b0);
    directed("100/-7",  8'h64, 4'h9, 8'hF2, 4'h2, 1'b0, 1'b0);
    directed("-100/-7", 8'h9C, 4'h9, 8'h0E, 4'hE, 1'b0, 1'b0);
    directed("-42/-8",  8'hD6, 4'h8, 8'h05, 4'hE, 1'b0, 1'b0);
    directed("56/-8",   8'h38, 4'h8, 8'hF9, 4'h0, 1'b0, 1'b0);
    directed("-128/-1", 8'h80, 4'hF, 8'h80, 4'h0, 1'b0, 1'b1);
    directed("37/0",    8'h25, 4'h0, 8'h00, 4'h0, 1'b1, 1'b0);
    directed("-128/7",  8'h80, 4'h7, 8'hEE, 4'hE, 1'b0, 1'b0);
    directed("127/-8",  8'h7F, 4'h8, 8'hF1, 4'h7, 1'b0, 1'b0);

    // Results hold after done until the next operation.
    @(posedge clk); @(negedge clk);
    check("hold q",    32'(q),    32'hF1);
    check("hold done", 32'(done), 32'd0);

    // Start held for three cycles with operands changing while busy.
    a = 8'h64; b = 4'h7; start = 1'b1;
    @(posedge clk); @(negedge clk);
    a = 8'h9C; b = 4'h3;
    @(posedge clk); @(negedge clk);
    a = 8'h05; b = 4'h1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    ndone = 0;
    repeat (15) begin
      @(posedge clk); @(negedge clk);
      if (done) begin
        ndone++;
        check("held q", 32'(q), 32'h0E);
        check("held r", 32'(r), 32'h2);
      end
    end
    check("held done count", 32'(ndone), 32'd1);

    // Asynchronous reset during CALC iteration 4.
    a = 8'h9C; b = 4'h9; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle_zero("abort");
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort no done", 32'(ndone), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    directed("post-reset", 8'h64, 4'h7, 8'h0E, 4'h2, 1'b0, 1'b0);

    // Random operands against a truncating-division model.
    for (int i = 0; i < 2000; i++) begin
      ra = N'($urandom);
      rb = M'($urandom);
      ia = int'($signed(ra));
      ib = int'($signed(rb));
      edz = 1'b0; eovf = 1'b0;
      if (ib == 0) begin
        qi = 0; ri = 0; edz = 1'b1;
      end else if (ia == -128 && ib == -1) begin
        qi = -128; ri = 0; eovf = 1'b1;
      end else begin
        qi = ia / ib;
        ri = ia % ib;
      end
      eq = qi[N-1:0];
      er = ri[M-1:0];
      run_op(ra, rb, lat, bc);
      check("rnd latency", 32'(lat), 32'd9);
      check("rnd q",   32'(q),   32'(eq));
      check("rnd r",   32'(r),   32'(er));
      check("rnd dz",  32'(dz),  32'(edz));
      check("rnd ovf", 32'(ovf), 32'(eovf));
      if (!edz && !eovf)
        check("rnd invariant", 32'(int'($signed(q)) * ib + int'($signed(r))), 32'(ia));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
